// File: rtl/cpu_io_sequencer_pkg.sv
// Shared encodings for the CPU I/O sequencer: FSM states, mailbox bit layout, port indices.
// Mailbox helpers keep the e3/s3 bit packing in one place.
package cpu_io_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_LOAD     = S_LOAD,
    ST_REQ      = S_REQ,
    ST_WAIT_ACK = S_WAIT_ACK,
    ST_WAIT_REL = S_WAIT_REL,
    ST_ERROR    = S_ERROR
  } state_t;

  localparam int MBX_REQ_BIT = 7;
  localparam int MBX_ACK_BIT = 7;
  localparam int MBX_TAG_LSB = 0;
  localparam int MBX_TAG_W   = 4;

  localparam int PORT_E0 = 0;
  localparam int PORT_E1 = 1;
  localparam int PORT_E2 = 2;
  localparam int PORT_E3 = 3;
  localparam int PORT_S0 = 0;
  localparam int PORT_S3 = 3;

  typedef logic [MBX_TAG_W-1:0] tag_t;

  function automatic logic [7:0] mbx_word(input logic req, input tag_t tag);
    logic [7:0] w;
    w = '0;
    w[MBX_REQ_BIT] = req;
    w[MBX_TAG_LSB +: MBX_TAG_W] = tag;
    return w;
  endfunction

  // An ack only counts when the program echoes the tag of the request in flight.
  function automatic logic mbx_ack_match(input logic [7:0] status, input tag_t tag);
    return status[MBX_ACK_BIT] && (status[MBX_TAG_LSB +: MBX_TAG_W] == tag);
  endfunction

endpackage

// File: rtl/cpu_io_sequencer_if.sv
// Memory-mapped port bundle between the board sequencer and the CPU.
// The sequencer drives the CPU input ports e0..e3 and reads output ports s0/s3.
interface cpu_io_sequencer_if;
  logic [7:0] e0;
  logic [7:0] e1;
  logic [7:0] e2;
  logic [7:0] e3;
  logic [7:0] s0;
  logic [7:0] s3;

  modport master (
    output e0, e1, e2, e3,
    input  s0, s3
  );

  modport slave (
    input  e0, e1, e2, e3,
    output s0, s3
  );
endinterface

// File: rtl/cpu_io_sequencer_sync_rise_pulse.sv
// Synchroniser for an asynchronous, debounced button plus a one-cycle rising-edge pulse.
// A held button yields a single pulse; the pulse depends only on flop outputs.
module sync_rise_pulse #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign pulse = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/cpu_io_sequencer.sv
// Board-side sequencer: snapshots switch operands on a button press, runs the tagged
// four-phase mailbox with the CPU program, latches its result and flags timeouts.
module cpu_io_sequencer
  import cpu_io_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                a,
  input  logic [3:0]                b,
  input  logic [2:0]                op,
  input  logic                      go,
  cpu_io_sequencer_if.master        cpu,
  output logic [7:0]                result,
  output logic                      result_valid,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  state_t               state_reg;
  tag_t                 tag_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [7:0]           e_reg [4];
  logic                 go_p;
  logic                 ack_hit;
  logic                 rel_seen;
  logic                 timer_expired;

  sync_rise_pulse #(
    .STAGES (SYNC_STAGES)
  ) u_go_sync (
    .clk   (clk),
    .reset (reset),
    .din   (go),
    .pulse (go_p)
  );

  assign ack_hit       = mbx_ack_match(cpu.s3, tag_reg);
  assign rel_seen      = ~cpu.s3[MBX_ACK_BIT];
  assign timer_expired = (timer_reg == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tag_reg      <= '0;
      timer_reg    <= '0;
      for (int i = 0; i < 4; i++) begin
        e_reg[i] <= '0;
      end
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      unique case (state_reg)
        // ERROR restarts exactly like IDLE; go_p in any busy state is simply ignored.
        ST_IDLE, ST_ERROR: begin
          if (go_p) begin
            e_reg[PORT_E0] <= {4'b0, a};
            e_reg[PORT_E1] <= {4'b0, b};
            e_reg[PORT_E2] <= {5'b0, op};
            tag_reg        <= tag_reg + 1'b1;
            busy           <= 1'b1;
            result_valid   <= 1'b0;
            timeout_err    <= 1'b0;
            state_reg      <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          state_reg <= ST_REQ;
        end

        ST_REQ: begin
          e_reg[PORT_E3] <= mbx_word(1'b1, tag_reg);
          timer_reg      <= '0;
          state_reg      <= ST_WAIT_ACK;
        end

        // Exit condition is tested before the timer so an ack on the last cycle still wins.
        ST_WAIT_ACK: begin
          if (ack_hit) begin
            result                      <= cpu.s0;
            e_reg[PORT_E3][MBX_REQ_BIT] <= 1'b0;
            timer_reg                   <= '0;
            state_reg                   <= ST_WAIT_REL;
          end else if (timer_expired) begin
            e_reg[PORT_E3] <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b1;
            state_reg      <= ST_ERROR;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_WAIT_REL: begin
          if (rel_seen) begin
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state_reg    <= ST_IDLE;
          end else if (timer_expired) begin
            e_reg[PORT_E3] <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b1;
            state_reg      <= ST_ERROR;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu.e0 = e_reg[PORT_E0];
  assign cpu.e1 = e_reg[PORT_E1];
  assign cpu.e2 = e_reg[PORT_E2];
  assign cpu.e3 = e_reg[PORT_E3];

endmodule

// File: tb/tb_cpu_io_sequencer.sv
// Randomised bench for cpu_io_sequencer with a cycle-stepped CPU mailbox model.
// Expected tags, results and latencies come from the handshake rules, not from the RTL.
module tb_cpu_io_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       go;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int passes = 0;
  int exp_tag = 0;

  cpu_io_sequencer_if cpu ();

  cpu_io_sequencer #(
    .TIMEOUT_CYC (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .op           (op),
    .go           (go),
    .cpu          (cpu),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] req_of(input int tag);
    return 8'h80 | 8'(tag);
  endfunction

  task automatic press_go(input logic [3:0] ta, input logic [3:0] tbv, input logic [2:0] to);
    a = ta; b = tbv; op = to; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Drives one transaction; the CPU acks ack_dly cycles after seeing the request
  // and releases rel_dly cycles after the request drops. Latency counts from busy.
  task automatic drive_txn(input logic [3:0] ta, input logic [3:0] tbv, input logic [2:0] to,
                           input int ack_dly, input logic [7:0] rv, input int rel_dly,
                           input bit stale, input bit toggle,
                           output int lat, output logic [7:0] req_word, output bit done);
    int phase;
    int cnt;
    cpu.s3 = 8'h00;
    cpu.s0 = ~rv;
    a = ta; b = tbv; op = to; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    lat = 0; done = 1'b0; req_word = 8'h00; phase = 0; cnt = 0;
    while (!done && lat < 200) begin
      if (toggle) begin
        a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
      end
      case (phase)
        0: if (cpu.e3[7]) begin
          req_word = cpu.e3;
          if (ack_dly == 0) begin
            cpu.s3 = 8'h80 | {4'h0, cpu.e3[3:0]};
            cpu.s0 = rv;
            phase = 2;
          end else begin
            if (stale) cpu.s3 = 8'h80 | {4'h0, cpu.e3[3:0] - 4'd1};
            phase = 1;
            cnt = 0;
          end
        end
        1: begin
          cnt++;
          if (cnt >= ack_dly) begin
            cpu.s3 = 8'h80 | {4'h0, req_word[3:0]};
            cpu.s0 = rv;
            phase = 2;
          end
        end
        2: if (!cpu.e3[7]) begin
          if (rel_dly == 0) begin
            cpu.s3 = 8'h00; phase = 4;
          end else begin
            phase = 3; cnt = 0;
          end
        end
        3: begin
          cnt++;
          if (cnt >= rel_dly) begin
            cpu.s3 = 8'h00; phase = 4;
          end
        end
        default: ;
      endcase
      tick();
      lat++;
      if (result_valid) done = 1'b1;
    end
    cpu.s3 = 8'h00;
    $display("txn tag=%0d a=%h b=%h op=%h result=%h latency=%0d done=%0d",
             req_word[3:0], ta, tbv, to, result, lat, done);
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; a = '0; b = '0; op = '0;
    cpu.s0 = 8'h00; cpu.s3 = 8'h00;
    repeat (3) tick();
    checks++;
    if ({cpu.e0, cpu.e1, cpu.e2, cpu.e3, result} !== 40'h0)
      $display("FAIL reset_data got=%h exp=0", {cpu.e0, cpu.e1, cpu.e2, cpu.e3, result});
    else passes++;
    checks++;
    if ({result_valid, busy, timeout_err} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {result_valid, busy, timeout_err});
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, cpu.e3} !== 9'h0) $display("FAIL reset_idle got=%h exp=0", {busy, cpu.e3});
    else passes++;
    exp_tag = 0;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] rw;
    bit done;
    drive_txn(4'h3, 4'h5, 3'b010, 6, 8'h08, 2, 1'b0, 1'b0, lat, rw, done);
    exp_tag = (exp_tag + 1) % 16;
    checks++;
    if (rw !== req_of(exp_tag)) $display("FAIL basic_req got=%h exp=%h", rw, req_of(exp_tag));
    else passes++;
    checks++;
    if ({cpu.e0, cpu.e1, cpu.e2} !== 24'h030502)
      $display("FAIL basic_operands got=%h exp=030502", {cpu.e0, cpu.e1, cpu.e2});
    else passes++;
    checks++;
    if ({done, result, result_valid, busy} !== {1'b1, 8'h08, 1'b1, 1'b0})
      $display("FAIL basic_result got=%b/%h/%b/%b exp=1/08/1/0", done, result, result_valid, busy);
    else passes++;
    checks++;
    if (cpu.e3 !== 8'(exp_tag)) $display("FAIL basic_e3_idle got=%h exp=%h", cpu.e3, 8'(exp_tag));
    else passes++;
    checks++;
    if (lat !== 12) $display("FAIL basic_latency got=%0d exp=12", lat);
    else passes++;
  endtask

  task automatic test_random();
    int lat, ad, rd, exp_lat;
    logic [7:0] rw, rv;
    logic [3:0] ta, tbv;
    logic [2:0] to;
    bit done;
    for (int i = 0; i < 5; i++) begin
      ta = 4'($urandom); tbv = 4'($urandom); to = 3'($urandom); rv = 8'($urandom);
      ad = (i == 0) ? 0 : $urandom_range(0, 10);
      rd = (i == 0) ? 0 : $urandom_range(0, 5);
      exp_lat = 4 + ad + rd;
      drive_txn(ta, tbv, to, ad, rv, rd, 1'b0, 1'b0, lat, rw, done);
      exp_tag = (exp_tag + 1) % 16;
      checks++;
      if (rw !== req_of(exp_tag)) $display("FAIL rand_req got=%h exp=%h", rw, req_of(exp_tag));
      else passes++;
      checks++;
      if ({cpu.e0, cpu.e1, cpu.e2} !== {4'h0, ta, 4'h0, tbv, 5'h0, to})
        $display("FAIL rand_operands got=%h exp=%h", {cpu.e0, cpu.e1, cpu.e2}, {4'h0, ta, 4'h0, tbv, 5'h0, to});
      else passes++;
      checks++;
      if (result !== rv) $display("FAIL rand_result got=%h exp=%h", result, rv);
      else passes++;
      checks++;
      if (lat !== exp_lat) $display("FAIL rand_latency got=%0d exp=%0d", lat, exp_lat);
      else passes++;
    end
  endtask

  task automatic test_stale();
    int lat;
    logic [7:0] rw, rv;
    bit done;
    rv = 8'($urandom);
    drive_txn(4'($urandom), 4'($urandom), 3'($urandom), 5, rv, 1, 1'b1, 1'b0, lat, rw, done);
    exp_tag = (exp_tag + 1) % 16;
    checks++;
    if (result !== rv) $display("FAIL stale_result got=%h exp=%h", result, rv);
    else passes++;
    checks++;
    if (lat !== 10) $display("FAIL stale_latency got=%0d exp=10", lat);
    else passes++;
  endtask

  task automatic test_timeout();
    int lat, n;
    logic [7:0] rw, rv;
    bit done, seen;
    // Ack arriving on the final allowed cycle must still complete.
    rv = 8'($urandom);
    drive_txn(4'($urandom), 4'($urandom), 3'($urandom), 15, rv, 0, 1'b0, 1'b0, lat, rw, done);
    exp_tag = (exp_tag + 1) % 16;
    checks++;
    if ({done, timeout_err, result} !== {1'b1, 1'b0, rv} || lat !== 19)
      $display("FAIL timeout_edge_ack got=%b/%b/%h lat=%0d exp=1/0/%h lat=19", done, timeout_err, result, lat, rv);
    else passes++;

    press_go(4'($urandom), 4'($urandom), 3'($urandom));
    exp_tag = (exp_tag + 1) % 16;
    seen = 1'b0;
    rw = 8'h00;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (cpu.e3[7]) begin
        seen = 1'b1; rw = cpu.e3;
      end
    end
    checks++;
    if (rw !== req_of(exp_tag)) $display("FAIL timeout_req got=%h exp=%h", rw, req_of(exp_tag));
    else passes++;
    n = 0;
    while (!timeout_err && n < 40) begin
      tick(); n++;
    end
    checks++;
    if (n !== 16) $display("FAIL timeout_cycles got=%0d exp=16", n);
    else passes++;
    checks++;
    if ({cpu.e3, busy, result_valid, timeout_err} !== {8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL timeout_state got=%h/%b/%b/%b exp=00/0/0/1", cpu.e3, busy, result_valid, timeout_err);
    else passes++;

    rv = 8'($urandom);
    drive_txn(4'($urandom), 4'($urandom), 3'($urandom), 2, rv, 1, 1'b0, 1'b0, lat, rw, done);
    exp_tag = (exp_tag + 1) % 16;
    checks++;
    if ({rw, timeout_err, done, result} !== {req_of(exp_tag), 1'b0, 1'b1, rv})
      $display("FAIL timeout_recover got=%h/%b/%b/%h exp=%h/0/1/%h", rw, timeout_err, done, result, req_of(exp_tag), rv);
    else passes++;
  endtask

  // go_mode 0: button held 50 cycles; go_mode 1: three short presses with a slow CPU.
  task automatic test_hold_and_drop(input int go_mode);
    int reqs;
    logic prev;
    logic [7:0] rw, rv;
    logic [3:0] ta, tbv;
    logic [2:0] to;
    ta = 4'($urandom); tbv = 4'($urandom); to = 3'($urandom); rv = 8'($urandom);
    a = ta; b = tbv; op = to;
    reqs = 0; prev = 1'b0; rw = 8'h00;
    for (int i = 0; i < 70; i++) begin
      go = (go_mode == 0) ? (i < 50) : (i == 0 || i == 6 || i == 10);
      cpu.s0 = rv;
      if (go_mode == 1 && i < 15) cpu.s3 = 8'h00;
      else cpu.s3 = cpu.e3[7] ? (8'h80 | {4'h0, cpu.e3[3:0]}) : 8'h00;
      if (cpu.e3[7] && !prev) begin
        reqs++; rw = cpu.e3;
      end
      prev = cpu.e3[7];
      tick();
    end
    cpu.s3 = 8'h00;
    exp_tag = (exp_tag + 1) % 16;
    $display("txn tag=%0d mode=%0d requests=%0d result=%h", rw[3:0], go_mode, reqs, result);
    checks++;
    if (reqs !== 1) $display("FAIL hold%0d_requests got=%0d exp=1", go_mode, reqs);
    else passes++;
    checks++;
    if (rw !== req_of(exp_tag)) $display("FAIL hold%0d_tag got=%h exp=%h", go_mode, rw, req_of(exp_tag));
    else passes++;
    checks++;
    if ({result, result_valid, busy} !== {rv, 1'b1, 1'b0})
      $display("FAIL hold%0d_result got=%h/%b/%b exp=%h/1/0", go_mode, result, result_valid, busy, rv);
    else passes++;
  endtask

  task automatic test_toggle();
    int lat;
    logic [7:0] rw, rv;
    logic [3:0] ta, tbv;
    logic [2:0] to;
    bit done;
    ta = 4'($urandom); tbv = 4'($urandom); to = 3'($urandom); rv = 8'($urandom);
    drive_txn(ta, tbv, to, 4, rv, 3, 1'b0, 1'b1, lat, rw, done);
    exp_tag = (exp_tag + 1) % 16;
    checks++;
    if ({cpu.e0, cpu.e1, cpu.e2} !== {4'h0, ta, 4'h0, tbv, 5'h0, to})
      $display("FAIL toggle_operands got=%h exp=%h", {cpu.e0, cpu.e1, cpu.e2}, {4'h0, ta, 4'h0, tbv, 5'h0, to});
    else passes++;
    checks++;
    if ({done, result} !== {1'b1, rv}) $display("FAIL toggle_result got=%b/%h exp=1/%h", done, result, rv);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, errs;
    logic [7:0] rw, rv;
    bit done, seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_tag = 0;
    errs = 0;
    for (int i = 1; i <= 17; i++) begin
      rv = 8'($urandom);
      drive_txn(4'($urandom), 4'($urandom), 3'($urandom), $urandom_range(0, 3), rv,
                $urandom_range(0, 2), 1'b0, 1'b0, lat, rw, done);
      exp_tag = (exp_tag + 1) % 16;
      checks++;
      if ({rw, done, result} !== {req_of(exp_tag), 1'b1, rv}) begin
        $display("FAIL b2b_txn%0d got=%h/%b/%h exp=%h/1/%h", i, rw, done, result, req_of(exp_tag), rv);
        errs++;
      end else passes++;
      if (i == 16) begin
        checks++;
        if (rw[3:0] !== 4'd0) $display("FAIL b2b_wrap got=%0d exp=0", rw[3:0]);
        else passes++;
      end
    end

    press_go(4'($urandom), 4'($urandom), 3'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (cpu.e3[7]) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL b2b_wait_ack got=%b exp=1", seen);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if ({cpu.e0, cpu.e1, cpu.e2, cpu.e3, result, result_valid, busy, timeout_err} !== 43'h0)
      $display("FAIL midreset_outputs got=%h exp=0",
               {cpu.e0, cpu.e1, cpu.e2, cpu.e3, result, result_valid, busy, timeout_err});
    else passes++;
    reset = 1'b0;
    exp_tag = 0;
    tick();
    rv = 8'($urandom);
    drive_txn(4'($urandom), 4'($urandom), 3'($urandom), 1, rv, 1, 1'b0, 1'b0, lat, rw, done);
    exp_tag = (exp_tag + 1) % 16;
    checks++;
    if ({rw, result} !== {req_of(exp_tag), rv})
      $display("FAIL midreset_next got=%h/%h exp=%h/%h", rw, result, req_of(exp_tag), rv);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_stale();
    test_timeout();
    test_hold_and_drop(0);
    test_hold_and_drop(1);
    test_toggle();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
